// File: rtl/fixdiv_pkg.sv
// fixdiv_pkg: shared constants and types for the iterative fixed-point divider.
//   DEF_W / DEF_FRAC   default operand width and fraction bits
//   DEF_QMAX / QMIN    saturation limits for the default width
//   DEF_ITERS          quotient bits produced per operation (one per cycle)
//   state_e            controller states
package fixdiv_pkg;

  localparam int DEF_W    = 16;
  localparam int DEF_FRAC = 8;

  localparam logic [DEF_W-1:0] DEF_QMAX = {1'b0, {(DEF_W-1){1'b1}}};
  localparam logic [DEF_W-1:0] DEF_QMIN = {1'b1, {(DEF_W-1){1'b0}}};

  // |dividend| << FRAC never exceeds 2^(W+FRAC-1), so W+FRAC restoring steps
  // cover every significant bit of the scaled dividend.
  function automatic int fixdiv_iters(input int w, input int frac);
    return w + frac;
  endfunction

  localparam int DEF_ITERS = fixdiv_iters(DEF_W, DEF_FRAC);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/fixdiv_step.sv
// fixdiv_step: one combinational restoring-division step.
//   rem_i   partial remainder before the step (W+2 bits)
//   bit_i   next dividend bit, shifted into the remainder LSB
//   dvsr_i  divisor magnitude (W+1 bits)
//   rem_o   partial remainder after the step
//   q_o     quotient bit produced by this step
module fixdiv_step
  import fixdiv_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic [W+1:0] rem_i,
  input  logic         bit_i,
  input  logic [W:0]   dvsr_i,
  output logic [W+1:0] rem_o,
  output logic         q_o
);

  // One guard bit above the shifted remainder keeps the compare exact.
  logic [W+2:0] shifted;
  logic [W+2:0] diff;

  // NOTE: every signal assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch.
  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {2'b00, dvsr_i};
    q_o     = (shifted >= {2'b00, dvsr_i});
    rem_o   = q_o ? (W+2)'(diff) : (W+2)'(shifted);
  end

endmodule

// File: rtl/seq_fixdiv.sv
// seq_fixdiv: iterative signed fixed-point divider, one quotient bit per cycle.
// Computes (dividend << FRAC) / divisor in Q(W-FRAC).FRAC, truncating toward
// zero and saturating to QMAX/QMIN.
//   clk, rst            clock (rising edge), async active-high reset
//   div_en              start request, honoured only when idle
//   dividend, divisor   signed operands, captured on the accepting edge
//   quotient            signed result, held until the next result
//   div_flag            one-cycle pulse: quotient valid
//   busy                operation in flight
//   div_by_zero         last operation had a zero divisor
//   overflow            last operation saturated
module seq_fixdiv
  import fixdiv_pkg::*;
#(
  parameter int W    = DEF_W,
  parameter int FRAC = DEF_FRAC
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         div_en,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic         div_flag,
  output logic         busy,
  output logic         div_by_zero,
  output logic         overflow
);

  localparam int SW = fixdiv_iters(W, FRAC);   // shift register / step count
  localparam int RW = W + 1 + FRAC;            // raw quotient width
  localparam int CW = $clog2(SW);

  localparam logic [W-1:0]  QMAX      = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  QMIN      = {1'b1, {(W-1){1'b0}}};
  localparam logic [RW-1:0] RAW_QMAX  = RW'(QMAX);
  localparam logic [RW-1:0] RAW_NEGLIM = RW'(1) << (W-1);

  state_e        state_q;
  logic          sign_q;
  logic [W:0]    dvd_abs_q;
  logic [W:0]    dvsr_abs_q;
  logic [SW-1:0] shreg_q;
  logic [W+1:0]  rem_q;
  logic [RW-1:0] raw_q;
  logic [CW-1:0] count_q;

  logic [W:0]    dvd_ext, dvsr_ext, dvd_abs, dvsr_abs;
  logic [W-1:0]  q_neg;
  logic [W+1:0]  rem_d;
  logic          qbit_d;

  // Magnitudes are W+1 bits so that |-2^(W-1)| is representable.
  always_comb begin
    dvd_ext  = {dividend[W-1], dividend};
    dvsr_ext = {divisor[W-1], divisor};
    dvd_abs  = dividend[W-1] ? -dvd_ext  : dvd_ext;
    dvsr_abs = divisor[W-1]  ? -dvsr_ext : dvsr_ext;
    q_neg    = -raw_q[W-1:0];
  end

  fixdiv_step #(.W(W)) u_step (
    .rem_i  (rem_q),
    .bit_i  (shreg_q[SW-1]),
    .dvsr_i (dvsr_abs_q),
    .rem_o  (rem_d),
    .q_o    (qbit_d)
  );

  // NOTE: all state, datapath registers included, is cleared by the async
  // reset so an aborted operation leaves nothing behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      dvd_abs_q   <= '0;
      dvsr_abs_q  <= '0;
      shreg_q     <= '0;
      rem_q       <= '0;
      raw_q       <= '0;
      count_q     <= '0;
      quotient    <= '0;
      div_flag    <= 1'b0;
      busy        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values, independent of statement order.
      div_flag <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (div_en) begin
            sign_q      <= dividend[W-1] ^ divisor[W-1];
            dvd_abs_q   <= dvd_abs;
            dvsr_abs_q  <= dvsr_abs;
            shreg_q     <= SW'({dvd_abs, {FRAC{1'b0}}});
            rem_q       <= '0;
            raw_q       <= '0;
            count_q     <= CW'(SW - 1);
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            busy        <= 1'b1;
            state_q     <= ITER;
          end
        end
        ITER: begin
          shreg_q <= {shreg_q[SW-2:0], 1'b0};
          rem_q   <= rem_d;
          raw_q   <= {raw_q[RW-2:0], qbit_d};
          if (count_q == '0) state_q <= FIN;
          else               count_q <= count_q - 1'b1;
        end
        FIN: begin
          if (dvsr_abs_q == '0) begin
            // Divisor sign bit is 0 here, so sign_q is the dividend's sign.
            div_by_zero <= 1'b1;
            if (dvd_abs_q == '0) quotient <= '0;
            else                 quotient <= sign_q ? QMIN : QMAX;
          end else if (!sign_q && raw_q > RAW_QMAX) begin
            quotient <= QMAX;
            overflow <= 1'b1;
          end else if (sign_q && raw_q > RAW_NEGLIM) begin
            quotient <= QMIN;
            overflow <= 1'b1;
          end else begin
            quotient <= sign_q ? q_neg : raw_q[W-1:0];
          end
          div_flag <= 1'b1;
          busy     <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/seq_fixdiv.md
Name: seq_fixdiv

Overview:
- Iterative signed fixed-point divider. It is the responder side of the neuron unit's divide handshake.
- The neuron unit presents diff2 as the dividend and sigma2 as the divisor, then pulses div_en.
- The block computes the normalised distance (dividend << FRAC) / divisor in Q(W-FRAC).FRAC, one quotient bit per cycle.
- It returns the result with a one-cycle div_flag pulse, and one instance serves each neuron unit.

Parameters:
W, 16, operand and quotient width (two's complement)
FRAC, 8, fraction bits of operands and quotient

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
div_en  in  1  start request; sampled only in IDLE
dividend  in  W  signed dividend; sampled on the accepting edge
divisor  in  W  signed divisor; sampled on the accepting edge
quotient  out  W  signed Q result; held until the next result is written
div_flag  out  1  one-cycle pulse, quotient valid
busy  out  1  high from the accepting edge until the edge that writes the result
div_by_zero  out  1  sticky per operation: divisor was 0
overflow  out  1  sticky per operation: result saturated

Behaviour:
- Reset (async, rst=1): state=IDLE; quotient=0, div_flag=0, busy=0, div_by_zero=0, overflow=0; all internal registers cleared. Reset mid-operation aborts the operation; no flag is issued afterwards.
- States: IDLE, ITER, FIN.
- IDLE, div_en=1 (edge T0):
  - latch sign = dividend[W-1] XOR divisor[W-1];
  - latch |dividend| as W+1 bits (|-32768|=32768 representable) and |divisor| as W+1 bits;
  - load the shift register with |dividend| << FRAC (W+1+FRAC bits) and clear the remainder (W+2 bits);
  - count = W+FRAC-1; clear div_by_zero and overflow; busy=1; go to ITER.
- ITER (edges T1..T(W+FRAC)), restoring step per edge:
  - rem' = {rem, msb of shift reg}; shift the shift reg left;
  - if rem' >= |divisor|: rem = rem' - |divisor| and the quotient bit is 1; else rem = rem' and the bit is 0;
  - the quotient bit shifts into the raw quotient (W+1+FRAC bits);
  - when count = 0 go to FIN, else decrement count.
- FIN (edge T(W+FRAC+1)):
  - divisor==0: div_by_zero=1; quotient = 0 if dividend==0, else QMAX if dividend>0, else QMIN.
  - else if sign=0 and raw > QMAX: quotient=QMAX, overflow=1.
  - else if sign=1 and raw > 2^(W-1): quotient=QMIN, overflow=1.
  - else quotient = sign ? -raw : raw, truncated to W bits (rounding toward zero).
  - div_flag=1, busy=0, go to IDLE.
- Latency is constant: div_flag is high in the cycle after edge T(W+FRAC+1), i.e. W+FRAC+1 = 25 edges after the accepting edge with defaults. The divide-by-zero path keeps the same latency.
- div_flag is high exactly one cycle. A div_en in that same cycle (state IDLE) is accepted, giving back-to-back operation. div_flag and busy are never high together.
- div_en while busy: ignored; operands are not resampled.
- Operand changes after T0 have no effect.
- QMAX = 2^(W-1)-1 (0x7FFF); QMIN = -2^(W-1) (0x8000).
- div_by_zero and overflow hold their value until the next accepting edge.

Decomposition:
- Package fixdiv_pkg: W, FRAC defaults; QMAX, QMIN constants; state enum {IDLE, ITER, FIN}; iteration count constant W+FRAC.
- One natural sub-module: fixdiv_step. It is the combinational restoring step (remainder, next dividend bit, |divisor| in; new remainder and quotient bit out), keeping seq_fixdiv to FSM plus datapath registers.

Test Plan:
- Basic: dividend=0x0200 (2.0), divisor=0x0100 (1.0), div_en for one cycle.
  - Required: busy=1 for 25 cycles, then div_flag pulse for one cycle with quotient=0x0200, overflow=0, div_by_zero=0.
- Truncation/sign:
  - 0x0100/0x0300 -> 0x0055.
  - 0xFF00 (-1.0)/0x0300 -> 0xFFAB.
  - 0xFF00/0xFD00 -> 0x0055.
- Saturation: 0x7FFF/0x0001 -> 0x7FFF, overflow=1. 0x8000/0x0100 -> 0x8000, overflow=0. 0x8000/0x0080 -> 0x8000, overflow=1.
- Divide by zero:
  - 0x0100/0 -> 0x7FFF, div_by_zero=1.
  - 0xFF00/0 -> 0x8000, div_by_zero=1.
  - 0/0 -> 0x0000, div_by_zero=1.
  - All three keep the same 25-cycle latency.
- Handshake:
  - div_en held high during busy with changing operands -> single result from the T0 operands.
  - div_en in the div_flag cycle -> second operation accepted, second flag 25 edges later.
- Reset mid-operation: assert rst at iteration 10 -> quotient=0, busy=0, no div_flag afterwards. A new div_en after reset produces a correct result.
